// File: rtl/uart_rx_pkg.sv
// ------------------------------------------------------------------
// uart_rx_pkg: FSM encoding and constants shared by the UART receiver.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package uart_rx_pkg;

  localparam int         DATA_BITS = 8;
  localparam logic [7:0] CR_CODE   = 8'h0D;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY    = 3'd3,
`endif
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ------------------------------------------------------------------
// sync_2ff: two-flop synchronizer with a configurable reset value.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/serial_char_rx.sv
// ------------------------------------------------------------------
// serial_char_rx: 8N1 UART receiver with 1-entry holding register; even parity via UART_RX_PARITY_EN.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module serial_char_rx
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       sys_clk,
  input  logic       RST,
  input  logic       rx_in,
  input  logic       enable_serial,
  output logic [7:0] char_in,
  output logic       newChar,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err,
  output logic       rx_busy
);

  localparam int            TW       = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] FULL_M1  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_M1  = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] ONE      = TW'(1);
  localparam logic [2:0]    LAST_IDX = 3'(DATA_BITS - 1);

  rx_state_t     state, state_n;
  logic          rx_s, rx_prev;
  logic [TW-1:0] timer, timer_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shift, shift_n;
  logic [7:0]    hold, hold_n;
  logic          valid, valid_n;
  logic [7:0]    char_n;
  logic          new_char_n, frame_err_n, overrun_n;
  logic          byte_done, deliver;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (sys_clk),
    .rst_n (RST),
    .d     (rx_in),
    .q     (rx_s)
  );

`ifdef UART_RX_PARITY_EN
  logic par_bad, par_bad_n, parity_err_n;
`endif

  assign rx_busy = (state != IDLE);

  always_ff @(posedge sys_clk or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      rx_prev   <= 1'b1;
      timer     <= '0;
      idx       <= '0;
      shift     <= '0;
      hold      <= '0;
      valid     <= 1'b0;
      char_in   <= 8'h00;
      newChar   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      rx_prev   <= rx_s;
      timer     <= timer_n;
      idx       <= idx_n;
      shift     <= shift_n;
      hold      <= hold_n;
      valid     <= valid_n;
      char_in   <= char_n;
      newChar   <= new_char_n;
      frame_err <= frame_err_n;
      overrun   <= overrun_n;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge sys_clk or negedge RST) begin
    if (!RST) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par_bad    <= par_bad_n;
      parity_err <= parity_err_n;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  always_comb begin
    state_n     = state;
    timer_n     = timer;
    idx_n       = idx;
    shift_n     = shift;
    hold_n      = hold;
    valid_n     = valid;
    char_n      = char_in;
    new_char_n  = 1'b0;
    frame_err_n = 1'b0;
    overrun_n   = 1'b0;
    byte_done   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_n    = par_bad;
    parity_err_n = 1'b0;
`endif
    // Blocking on the previous newChar keeps delivery pulses non-adjacent.
    deliver     = valid && enable_serial && !newChar;

    case (state)
      IDLE: begin
        timer_n = '0;
        idx_n   = '0;
`ifdef UART_RX_PARITY_EN
        par_bad_n = 1'b0;
`endif
        if (rx_prev && !rx_s) state_n = START;
      end
      START: begin
        if (timer == HALF_M1) begin
          timer_n = '0;
          state_n = rx_s ? IDLE : DATA;
        end else begin
          timer_n = timer + ONE;
        end
      end
      DATA: begin
        if (timer == FULL_M1) begin
          timer_n = '0;
          shift_n = {rx_s, shift[7:1]};
          idx_n   = idx + 3'd1;
          if (idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end else begin
          timer_n = timer + ONE;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (timer == FULL_M1) begin
          timer_n = '0;
          state_n = STOP;
          if (rx_s != ^shift) begin
            parity_err_n = 1'b1;
            par_bad_n    = 1'b1;
          end
        end else begin
          timer_n = timer + ONE;
        end
      end
`endif
      STOP: begin
        if (timer == FULL_M1) begin
          timer_n = '0;
          if (rx_s) begin
            state_n = IDLE;
`ifdef UART_RX_PARITY_EN
            byte_done = !par_bad;
`else
            byte_done = 1'b1;
`endif
          end else begin
            frame_err_n = 1'b1;
            state_n     = WAIT_HIGH;
          end
        end else begin
          timer_n = timer + ONE;
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (deliver) begin
      char_n     = hold;
      new_char_n = 1'b1;
      valid_n    = 1'b0;
    end
    // A delivery in the same cycle frees the slot for the incoming byte.
    if (byte_done) begin
      if (!valid || deliver) begin
        hold_n  = shift;
        valid_n = 1'b1;
      end else begin
        overrun_n = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_char_rx.sv
// ------------------------------------------------------------------
// tb_serial_char_rx: directed self-checking bench for serial_char_rx at CLKS_PER_BIT=8.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_serial_char_rx;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_in = 1'b1;
  logic       enable_serial = 1'b1;
  logic [7:0] char_in;
  logic       newChar, frame_err, overrun, parity_err, rx_busy;

  int total = 0;
  int bad   = 0;

  int cyc = 0, nc_count = 0, fe_count = 0, ov_count = 0, pe_count = 0;
  int consec = 0, nc_cycle = 0, busy_fall_cycle = 0;
  logic nc_prev = 1'b0, busy_prev = 1'b0;
  logic [7:0] caps [0:63];

  serial_char_rx #(.CLKS_PER_BIT(CPB)) dut (
    .sys_clk       (clk),
    .RST           (rst),
    .rx_in         (rx_in),
    .enable_serial (enable_serial),
    .char_in       (char_in),
    .newChar       (newChar),
    .frame_err     (frame_err),
    .overrun       (overrun),
    .parity_err    (parity_err),
    .rx_busy       (rx_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (newChar) begin
      if (nc_prev) consec <= consec + 1;
      caps[nc_count[5:0]] <= char_in;
      nc_count <= nc_count + 1;
      nc_cycle <= cyc;
    end
    nc_prev <= newChar;
    if (busy_prev && !rx_busy) busy_fall_cycle <= cyc;
    busy_prev <= rx_busy;
    if (frame_err)  fe_count <= fe_count + 1;
    if (overrun)    ov_count <= ov_count + 1;
    if (parity_err) pe_count <= pe_count + 1;
  end

  task automatic drive_bit(input logic b);
    rx_in = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] data, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^data);
`endif
    drive_bit(stop_bit);
    rx_in = 1'b1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total += 6;
    if (char_in !== 8'h00)  begin bad++; $display("FAIL reset_char: got %h expected 00", char_in); end
    if (newChar !== 1'b0)   begin bad++; $display("FAIL reset_newChar: got %b expected 0", newChar); end
    if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    if (overrun !== 1'b0)   begin bad++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    if (parity_err !== 1'b0) begin bad++; $display("FAIL reset_parity_err: got %b expected 0", parity_err); end
    if (rx_busy !== 1'b0)   begin bad++; $display("FAIL reset_rx_busy: got %b expected 0", rx_busy); end
    rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic;
    int nc0 = nc_count, fe0 = fe_count, ov0 = ov_count, pe0 = pe_count;
    enable_serial = 1'b1;
    send_byte(8'h41, 1'b1);
    repeat (16) @(negedge clk);
    chk("basic_newChar_count", nc_count - nc0, 1);
    chk("basic_char", int'(char_in), 'h41);
    chk("basic_latency", nc_cycle - busy_fall_cycle, 1);
    chk("basic_errors", (fe_count - fe0) + (ov_count - ov0) + (pe_count - pe0), 0);
  endtask

  task automatic test_false_start;
    int nc0 = nc_count, fe0 = fe_count;
    logic seen = 1'b0;
    rx_in = 1'b0;
    repeat (2) @(negedge clk);
    rx_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rx_busy) seen = 1'b1;
    end
    chk("false_start_busy_seen", int'(seen), 1);
    chk("false_start_busy_low", int'(rx_busy), 0);
    repeat (20) @(negedge clk);
    chk("false_start_newChar", nc_count - nc0, 0);
    chk("false_start_frame_err", fe_count - fe0, 0);
  endtask

  task automatic test_frame_err;
    int nc0 = nc_count, fe0 = fe_count;
    send_byte(8'h0D, 1'b0);
    rx_in = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    chk("frame_err_count", fe_count - fe0, 1);
    chk("frame_err_wait_high_busy", int'(rx_busy), 1);
    rx_in = 1'b1;
    repeat (6) @(negedge clk);
    chk("frame_err_idle_after_rise", int'(rx_busy), 0);
    repeat (20) @(negedge clk);
    chk("frame_err_newChar", nc_count - nc0, 0);
  endtask

  task automatic test_overrun;
    int nc0 = nc_count, ov0 = ov_count;
    enable_serial = 1'b0;
    send_byte(8'h41, 1'b1);
    repeat (20) @(negedge clk);
    chk("overrun_after_first", ov_count - ov0, 0);
    send_byte(8'h42, 1'b1);
    repeat (20) @(negedge clk);
    chk("overrun_after_second", ov_count - ov0, 1);
    chk("overrun_no_delivery", nc_count - nc0, 0);
    enable_serial = 1'b1;
    repeat (5) @(negedge clk);
    chk("overrun_delivery_count", nc_count - nc0, 1);
    chk("overrun_held_char", int'(char_in), 'h41);
    repeat (30) @(negedge clk);
    chk("overrun_single_delivery", nc_count - nc0, 1);
  endtask

  task automatic test_back_to_back;
    int nc0 = nc_count;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h0D, 1'b1);
    repeat (16) @(negedge clk);
    chk("b2b_count", nc_count - nc0, 2);
    chk("b2b_first", int'(caps[nc0[5:0]]), 'hA5);
    chk("b2b_second", int'(char_in), 'h0D);
  endtask

  task automatic test_reset_midframe;
    int nc0;
    logic [7:0] d = 8'h55;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rx_in = d[4];
    repeat (4) @(negedge clk);
    chk("midframe_busy_before_reset", int'(rx_busy), 1);
    rst = 1'b0;
    rx_in = 1'b1;
    @(negedge clk);
    chk("midframe_reset_outputs", int'({char_in, newChar, frame_err, overrun, parity_err, rx_busy}), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    nc0 = nc_count;
    repeat (3 * CPB) @(negedge clk);
    chk("midframe_no_delivery", nc_count - nc0, 0);
    chk("midframe_idle", int'(rx_busy), 0);
    send_byte(8'h32, 1'b1);
    repeat (16) @(negedge clk);
    chk("midframe_after_count", nc_count - nc0, 1);
    chk("midframe_after_char", int'(char_in), 'h32);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int nc0 = nc_count, pe0 = pe_count, fe0 = fe_count;
    logic [7:0] d = 8'h41;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(~(^d));
    drive_bit(1'b1);
    repeat (16) @(negedge clk);
    chk("parity_err_count", pe_count - pe0, 1);
    chk("parity_no_delivery", nc_count - nc0, 0);
    chk("parity_no_frame_err", fe_count - fe0, 0);
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_false_start;
    test_frame_err;
    test_overrun;
    test_back_to_back;
    test_reset_midframe;
`ifdef UART_RX_PARITY_EN
    test_parity;
`endif
    chk("newChar_never_consecutive", consec, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_char_rx.md
SERIAL_CHAR_RX -- requirements
Module: serial_char_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 217, meaning sys_clk cycles per UART bit (115200 baud at 25 MHz), legal range 4..4095.
REQ-002 SHALL have port sys_clk, input, 1, the single clock for all logic.
REQ-003 SHALL have port RST, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port rx_in, input, 1, asynchronous UART line, idle high.
REQ-005 SHALL have port enable_serial, input, 1, consumer ready; delivery is allowed only while it is high.
REQ-006 SHALL have port char_in, output, 8, last delivered byte, held stable between deliveries.
REQ-007 SHALL have port newChar, output, 1, one-cycle pulse marking a fresh char_in.
REQ-008 SHALL have port frame_err, output, 1, one-cycle pulse when the stop bit is sampled low.
REQ-009 SHALL have port overrun, output, 1, one-cycle pulse when a completed byte is dropped because the holding register is full.
REQ-010 SHALL have port parity_err, output, 1, one-cycle pulse on parity mismatch (see REQ-026).
REQ-011 SHALL have port rx_busy, output, 1, high in every state except IDLE.

Function
REQ-012 SHALL pass rx_in through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-013 SHALL implement the FSM states IDLE, START, DATA, PARITY, STOP and WAIT_HIGH.
- IDLE -> START on a synchronized high-to-low transition.
REQ-014 In START, SHALL count to CLKS_PER_BIT/2 (integer division) and sample the line:
- low -> DATA with the bit timer cleared;
- high -> IDLE (false start), with no output pulses.
REQ-015 In DATA, SHALL sample every CLKS_PER_BIT cycles, LSB first, 8 bits, then go to STOP (or PARITY when enabled).
REQ-016 In STOP, SHALL sample after CLKS_PER_BIT cycles:
- high -> the byte is loaded into the holding register and the FSM goes to IDLE;
- low -> frame_err pulses, the byte is discarded and the FSM goes to WAIT_HIGH.
REQ-017 WAIT_HIGH SHALL stay until the synchronized line is high, then go to IDLE; no new start is detected while waiting (break handling).
REQ-018 SHALL have a 1-entry holding register with a valid flag.
- Delivery: on a rising edge where valid=1 and enable_serial=1, char_in <= hold, newChar=1 for exactly that cycle, and valid clears.
REQ-019 Latency: with enable_serial high and hold empty, newChar SHALL be asserted exactly one clock after the stop-bit sample edge.
REQ-020 If a byte completes while valid=1 and no delivery occurs that cycle, SHALL pulse overrun, drop the new byte and retain the held byte.
REQ-021 If a byte completes in the same cycle a delivery empties hold, SHALL accept the new byte without overrun; newChar for it follows no earlier than the next cycle.
REQ-022 newChar SHALL never be high on two consecutive cycles.
REQ-023 Bit timer SHALL be ceil(log2(CLKS_PER_BIT)) bits wide and never wrap within a bit.

Reset
REQ-024 On RST low, SHALL asynchronously set:
- FSM = IDLE;
- synchronizer flops = 1;
- bit timer, bit index, shift register, hold and valid = 0;
- char_in = 8'h00;
- newChar, frame_err, overrun, parity_err and rx_busy = 0.
REQ-025 Reset mid-frame SHALL abandon the frame; after RST rises, reception resumes only on a new falling edge.

Configuration
REQ-026 Macro UART_RX_PARITY_EN:
- defined: the PARITY state samples an even-parity bit after bit 7; on mismatch parity_err pulses, the byte is discarded and STOP is still checked;
- undefined: the PARITY state is absent, DATA goes to STOP directly, and parity_err is tied 0.

Structure
REQ-027 Package uart_rx_pkg SHALL hold the FSM state encoding, the DATA_BITS=8 constant and the CR code 8'h0D.
REQ-028 SHALL instantiate one sub-module, sync_2ff (parameterized reset value), for rx_in; all other logic is flat.

Verification (CLKS_PER_BIT=8)
REQ-029 Send 0x41 (8N1) with enable_serial=1 -> char_in=0x41, newChar one cycle wide, 1 clock after the stop sample; no error pulses.
REQ-030 Drive rx_in low for 2 clocks, then high -> no newChar, no frame_err, rx_busy returns low within 6 clocks.
REQ-031 Send 0x0D with the stop bit forced low -> one frame_err pulse, no newChar; FSM stays in WAIT_HIGH until the line rises.
REQ-032 Hold enable_serial=0, send 0x41 then 0x42 -> overrun pulses once after 0x42; raising enable_serial gives exactly one newChar with char_in=0x41.
REQ-033 Assert RST during bit 4 of 0x55, release it, then send 0x32 -> all outputs are 0 during reset, and only 0x32 is delivered.
REQ-034 With UART_RX_PARITY_EN, send 0x41 with an odd parity bit -> parity_err pulses, no newChar.
